// File: rtl/mvu_pe_acc_if.sv
// Stream bundle for the per-PE accumulator: partial sums in, accumulated results out.
// The slave modport is the accumulator's view; the master modport is the view of
// whatever drives the partial sums and consumes the results.
interface mvu_pe_acc_if #(
    parameter int TDstI = 16,
    parameter int TO    = 24
);
    logic             in_v;
    logic             in_ready;
    logic [TDstI-1:0] in_data;
    logic             out_v;
    logic             out_ready;
    logic [TO-1:0]    out_data;
    logic             out_last;

    modport master (
        output in_v, in_data, out_ready,
        input  in_ready, out_v, out_data, out_last
    );

    modport slave (
        input  in_v, in_data, out_ready,
        output in_ready, out_v, out_data, out_last
    );
endinterface

// File: rtl/mvu_pe_acc.sv
// Per-PE accumulator sitting after the popcount/adder tree. It folds SF consecutive
// partial sums into one neuron result, holds that result in a valid/ready output
// register, and flags the last result of every NF-result neuron-fold group.
module mvu_pe_acc #(
    parameter int TDstI     = 16,
    parameter int TO        = 24,
    parameter int SF        = 4,
    parameter int NF        = 2,
    parameter int IN_SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    mvu_pe_acc_if.slave  bus
);
    localparam int SFW = $clog2((SF > 2) ? SF : 2);
    localparam int NFW = $clog2((NF > 2) ? NF : 2);
    localparam logic [SFW-1:0] SF_LAST = SFW'(SF - 1);
    localparam logic [NFW-1:0] NF_LAST = NFW'(NF - 1);

    logic [SFW-1:0] sf_cnt;
    logic [NFW-1:0] nf_cnt;
    logic [TO-1:0]  acc;
    logic [TO-1:0]  ext_in;
    logic [TO-1:0]  out_data_q;
    logic           out_v_q;
    logic           out_last_q;
    logic           last_beat;
    logic           accept;
    logic           in_ready_c;

    // Widen the partial sum to accumulator width: signed trees sign-extend, popcounts zero-extend.
    always_comb begin
        if (IN_SIGNED != 0) begin
            ext_in = TO'($signed(bus.in_data));
        end else begin
            ext_in = TO'(bus.in_data);
        end
    end

    // Only the closing beat of a fold can stall, and only while an undrained result blocks the output register.
    always_comb begin
        last_beat  = (sf_cnt == SF_LAST);
        in_ready_c = !last_beat || !out_v_q || bus.out_ready;
        accept     = bus.in_v && in_ready_c;
    end

    // Fold accumulation, result load with group tagging, and output drain; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sf_cnt     <= '0;
            nf_cnt     <= '0;
            acc        <= '0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (out_v_q && bus.out_ready) begin
                out_v_q <= 1'b0;
            end
            if (accept) begin
                if (last_beat) begin
                    out_data_q <= (SF == 1) ? ext_in : acc + ext_in;
                    out_v_q    <= 1'b1;
                    sf_cnt     <= '0;
                    out_last_q <= (nf_cnt == NF_LAST);
                    nf_cnt     <= (nf_cnt == NF_LAST) ? '0 : nf_cnt + NFW'(1);
                end else begin
                    acc    <= (sf_cnt == '0) ? ext_in : acc + ext_in;
                    sf_cnt <= sf_cnt + SFW'(1);
                end
            end
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.out_v    = out_v_q;
    assign bus.out_data = out_data_q;
    assign bus.out_last = out_last_q;
endmodule

// File: doc/mvu_pe_acc.md
Name: mvu_pe_acc

Overview:
- Per-PE accumulator directly downstream of the PE popcount/adder tree.
- Sums SF consecutive partial sums (one per synapse fold, SF = MatrixW/SIMD) into one output-neuron result.
- Presents each result on a valid/ready output register.
- Tags the last of every NF results (one neuron fold group) with out_last, for the stream output stage.

Parameters:
- TDstI, 16, width of partial-sum input from the adder tree.
- TO, 24, accumulator and output width; TO >= TDstI.
- SF, 4, partial sums per result; SF >= 1.
- NF, 2, results per neuron-fold group; NF >= 1.
- IN_SIGNED, 0, 1 = input two's complement (sign-extend); 0 = unsigned popcount (zero-extend).

Ports:
- clk  in  1  main clock
- rst_n  in  1  synchronous, active-low reset
- in_v  in  1  partial sum valid
- in_ready  out  1  block can accept in_data this cycle
- in_data  in  TDstI  partial sum from adder tree
- out_v  out  1  accumulated result valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  TO  accumulated result
- out_last  out  1  result is the NF-th of its group; qualified by out_v

Behaviour:
- Reset (rst_n low at posedge clk) has priority over all other events, including mid-fold and mid-handshake. It clears:
  - sf_cnt = 0, nf_cnt = 0, acc = 0
  - out_v = 0, out_data = 0, out_last = 0
  - Any partial accumulation is discarded.
- Extension: in_data is extended to TO bits (sign-extended if IN_SIGNED = 1, else zero-extended). All sums wrap modulo 2^TO; there is no saturation.
- Input accept: a beat is accepted when in_v && in_ready.
- in_ready is combinational: in_ready = (sf_cnt != SF-1) || !out_v || out_ready.
  - Input stalls only on the final beat of a fold while the output register holds an unaccepted result.
  - in_data is never dropped.
- Accepted beat with sf_cnt < SF-1:
  - acc <= (sf_cnt == 0) ? ext(in_data) : acc + ext(in_data)
  - sf_cnt <= sf_cnt + 1
- Accepted beat with sf_cnt == SF-1:
  - out_data <= (SF == 1) ? ext(in_data) : acc + ext(in_data)
  - out_v <= 1, sf_cnt <= 0
  - out_last <= (nf_cnt == NF-1)
  - nf_cnt <= (nf_cnt == NF-1) ? 0 : nf_cnt + 1
- Latency: out_v rises the cycle after the final beat of a fold is accepted (1-cycle latency).
- Output handshake:
  - out_v && out_ready with no new result loading: out_v <= 0 next cycle.
  - Simultaneous drain and new final beat: out_v stays 1 and out_data/out_last update to the new result. Full throughput, no bubble.
  - While out_v && !out_ready: out_data and out_last are held stable.
- Input gaps: in_v low mid-fold holds acc and sf_cnt indefinitely. Gaps never corrupt the sum.
- SF == 1: every accepted beat produces a result. acc is unused and may be optimised away.
- NF == 1: out_last is 1 on every result.
- Counters: sf_cnt and nf_cnt widths are clog2 of max(SF,2) and max(NF,2). Both wrap exactly at SF-1 and NF-1.

Test Plan:
- Basic fold: SF=4, IN_SIGNED=0, out_ready=1; inputs 3,5,7,9 on consecutive cycles -> out_data=24, out_v high for exactly 1 cycle, the cycle after the 4th beat; out_last=0.
- Group tagging: NF=2; two folds with inputs 1,1,1,1 then 2,2,2,2 -> results 4 (out_last=0), then 8 (out_last=1); third fold's out_last=0.
- Backpressure and throughput:
  - out_ready=0 while a result (24) is pending and the next fold's beats 1,2,3 arrive -> beats accepted; in_ready drops at 4th beat (value 4); out_data stays 24.
  - Raise out_ready -> 24 is consumed; next cycle out_data=10.
  - Continuous out_ready=1 with back-to-back folds -> one result every SF cycles, no bubbles.
- Signed/wrap: IN_SIGNED=1, TDstI=16, TO=24; inputs 0xFFFF, 0xFFFE, 5, 0 -> out_data=2. Then IN_SIGNED=0, TO=16, four inputs of 0x8000 -> out_data=0 (wrap).
- Gaps and SF=1: SF=4 with in_v low 3 cycles between beats 2 and 3 of 10,20,30,40 -> out_data=100. With SF=1, inputs 6,7 -> outputs 6, 7 on consecutive cycles.
- Reset mid-operation: assert rst_n=0 after 2 beats of a fold and with out_v=1 pending -> next cycle out_v=0, out_last=0, out_data=0. Next full fold 1,2,3,4 -> out_data=10, out_last per fresh nf_cnt=0.
